// File: rtl/eth_rx_mac_filter.sv
// Ethernet RX destination-MAC filter: accept/drop decision on the first beat of
// each frame, one registered forwarding stage, and per-class frame counters.
module eth_rx_mac_filter #(
   parameter int DATA_WIDTH = 256,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  sysclk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_axis_data,
   input  logic                  s_axis_valid,
   input  logic [KEEP_WIDTH-1:0] s_axis_keep,
   input  logic                  s_axis_last,
   output logic                  s_axis_ready,
   output logic [DATA_WIDTH-1:0] m_axis_data,
   output logic                  m_axis_valid,
   output logic [KEEP_WIDTH-1:0] m_axis_keep,
   output logic                  m_axis_last,
   input  logic                  m_axis_ready,
   input  logic [47:0]           local_mac,
   input  logic                  promisc_en,
   input  logic                  mcast_en,
   input  logic                  cnt_clr,
   output logic [31:0]           pass_cnt,
   output logic [31:0]           drop_cnt,
   output logic [31:0]           runt_cnt,
   output logic [31:0]           tcp_cnt,
   output logic [31:0]           udp_cnt
);

   // state | meaning
   // IDLE  | waiting for the first beat of a frame
   // PASS  | forwarding the rest of an accepted frame
   // DROP  | swallowing the rest of a filtered frame
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PASS = 2'd1;
   localparam logic [1:0] ST_DROP = 2'd2;

   logic [1:0]  state;
   logic [47:0] dmac;
   logic [15:0] ethertype;
   logic [3:0]  ip_version;
   logic [7:0]  ip_proto;
   logic        in_acc;
   logic        first_acc;
   logic        runt;
   logic        hit;
   logic        fwd;
   logic        is_ipv4;
   logic        is_tcp;
   logic        is_udp;

   // Wire byte 0 is the most significant byte of the MAC address.
   assign dmac       = {s_axis_data[7:0],   s_axis_data[15:8],  s_axis_data[23:16],
                        s_axis_data[31:24], s_axis_data[39:32], s_axis_data[47:40]};
   assign ethertype  = {s_axis_data[103:96], s_axis_data[111:104]};
   assign ip_version = s_axis_data[119:116];
   assign ip_proto   = s_axis_data[191:184];

   assign s_axis_ready = (state == ST_DROP) | ~m_axis_valid | m_axis_ready;
   assign in_acc       = s_axis_valid & s_axis_ready;
   assign first_acc    = in_acc & (state == ST_IDLE);

   assign runt = s_axis_last & ~s_axis_keep[13];
   assign hit  = (dmac == local_mac) | (dmac == 48'hFFFF_FFFF_FFFF)
               | (mcast_en & s_axis_data[0]) | promisc_en;
   assign fwd  = (first_acc & ~runt & hit) | (in_acc & (state == ST_PASS));

   // Header fields are only trusted when their bytes are covered by keep.
   assign is_ipv4 = s_axis_keep[14] & (ethertype == 16'h0800) & (ip_version == 4'h4);
   assign is_tcp  = is_ipv4 & s_axis_keep[23] & (ip_proto == 8'd6);
   assign is_udp  = is_ipv4 & s_axis_keep[23] & (ip_proto == 8'd17);

   always_ff @(posedge sysclk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else if (in_acc) begin
         case (state)
            ST_IDLE: begin
               if (!s_axis_last) state <= hit ? ST_PASS : ST_DROP;
            end
            ST_PASS, ST_DROP: begin
               if (s_axis_last) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge sysclk) begin
      if (rst) begin
         m_axis_valid <= 1'b0;
         m_axis_data  <= '0;
         m_axis_keep  <= '0;
         m_axis_last  <= 1'b0;
      end else if (fwd) begin
         m_axis_valid <= 1'b1;
         m_axis_data  <= s_axis_data;
         m_axis_keep  <= s_axis_keep;
         m_axis_last  <= s_axis_last;
      end else if (m_axis_ready) begin
         m_axis_valid <= 1'b0;
      end
   end

   always_ff @(posedge sysclk) begin
      if (rst || cnt_clr) begin
         pass_cnt <= '0;
         drop_cnt <= '0;
         runt_cnt <= '0;
         tcp_cnt  <= '0;
         udp_cnt  <= '0;
      end else if (first_acc) begin
         if (runt) begin
            runt_cnt <= runt_cnt + 32'd1;
         end else if (!hit) begin
            drop_cnt <= drop_cnt + 32'd1;
         end else begin
            pass_cnt <= pass_cnt + 32'd1;
            if (is_tcp) tcp_cnt <= tcp_cnt + 32'd1;
            if (is_udp) udp_cnt <= udp_cnt + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_eth_rx_mac_filter.sv
// Bench for eth_rx_mac_filter: directed scenarios plus randomized frames checked
// against a frame-level reference model and an expected-beat queue.
module tb_eth_rx_mac_filter;
   localparam int DW = 256;
   localparam int KW = DW / 8;

   logic          sysclk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] s_axis_data = '0;
   logic          s_axis_valid = 1'b0;
   logic [KW-1:0] s_axis_keep = '0;
   logic          s_axis_last = 1'b0;
   logic          s_axis_ready;
   logic [DW-1:0] m_axis_data;
   logic          m_axis_valid;
   logic [KW-1:0] m_axis_keep;
   logic          m_axis_last;
   logic          m_axis_ready = 1'b0;
   logic [47:0]   local_mac = 48'h02_11_22_33_44_55;
   logic          promisc_en = 1'b0;
   logic          mcast_en = 1'b0;
   logic          cnt_clr = 1'b0;
   logic [31:0]   pass_cnt, drop_cnt, runt_cnt, tcp_cnt, udp_cnt;

   always #5 sysclk = ~sysclk;

   eth_rx_mac_filter #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut (
      .sysclk(sysclk), .rst(rst),
      .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid), .s_axis_keep(s_axis_keep),
      .s_axis_last(s_axis_last), .s_axis_ready(s_axis_ready),
      .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid), .m_axis_keep(m_axis_keep),
      .m_axis_last(m_axis_last), .m_axis_ready(m_axis_ready),
      .local_mac(local_mac), .promisc_en(promisc_en), .mcast_en(mcast_en), .cnt_clr(cnt_clr),
      .pass_cnt(pass_cnt), .drop_cnt(drop_cnt), .runt_cnt(runt_cnt),
      .tcp_cnt(tcp_cnt), .udp_cnt(udp_cnt)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   int unsigned cyc = 0;
   bit          rand_rdy = 1'b0;
   bit          chk_bp = 1'b0;
   bit          mid_flip = 1'b0;
   int          stalls = 0;
   logic [DW-1:0] fd[$], got_d[$], exp_d[$];
   logic [KW-1:0] fk[$], got_k[$], exp_k[$];
   logic          got_l[$], exp_l[$];
   int unsigned   got_c[$], acc_c[$];
   logic [31:0]   e_pass = 0, e_drop = 0, e_runt = 0, e_tcp = 0, e_udp = 0;

   always @(posedge sysclk) cyc++;

   always @(posedge sysclk) begin
      #1;
      if (rand_rdy) m_axis_ready = 1'($urandom_range(0, 1));
   end

   // Output beats are recorded on the falling edge when a transfer is pending.
   always @(negedge sysclk) begin
      if (!rst && m_axis_valid && m_axis_ready) begin
         got_d.push_back(m_axis_data);
         got_k.push_back(m_axis_keep);
         got_l.push_back(m_axis_last);
         got_c.push_back(cyc);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Frame-level reference: 0 = forward, 1 = address drop, 2 = runt.
   function automatic int classify(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                   input bit is_last, output bit tcp, output bit udp);
      int nb;
      bit uni, bc;
      logic [7:0] b [24];
      nb = $countones(k);
      for (int i = 0; i < 24; i++) b[i] = d[8*i +: 8];
      tcp = 1'b0;
      udp = 1'b0;
      if (is_last && nb < 14) return 2;
      uni = 1'b1;
      bc  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (b[i] != local_mac[47-8*i -: 8]) uni = 1'b0;
         if (b[i] != 8'hFF) bc = 1'b0;
      end
      if (!(uni || bc || (mcast_en && b[0][0]) || promisc_en)) return 1;
      if (nb >= 24 && b[12] == 8'h08 && b[13] == 8'h00 && b[14][7:4] == 4'h4) begin
         tcp = (b[23] == 8'd6);
         udp = (b[23] == 8'd17);
      end
      return 0;
   endfunction

   task automatic build_frame(input logic [47:0] dmac, input logic [15:0] et, input logic [7:0] vihl,
                              input logic [7:0] proto, input int nbeats, input int last_bytes);
      logic [DW-1:0] d;
      logic [63:0]   m;
      fd.delete();
      fk.delete();
      for (int b = 0; b < nbeats; b++) begin
         for (int w = 0; w < DW / 32; w++) d[32*w +: 32] = $urandom;
         if (b == 0) begin
            for (int i = 0; i < 6; i++) d[8*i +: 8] = dmac[47-8*i -: 8];
            d[96 +: 8]  = et[15:8];
            d[104 +: 8] = et[7:0];
            d[112 +: 8] = vihl;
            d[184 +: 8] = proto;
         end
         m = (64'd1 << ((b == nbeats - 1) ? last_bytes : KW)) - 64'd1;
         fd.push_back(d);
         fk.push_back(m[KW-1:0]);
      end
   endtask

   task automatic drive_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
      int waits = 0;
      s_axis_data  = d;
      s_axis_keep  = k;
      s_axis_last  = l;
      s_axis_valid = 1'b1;
      forever begin
         @(negedge sysclk);
         if (chk_bp) begin
            n_cmp++;
            if (s_axis_ready !== (!m_axis_valid || m_axis_ready)) begin
               n_err++;
               $display("FAIL bp_ready: s_axis_ready=%b with m_valid=%b m_ready=%b",
                        s_axis_ready, m_axis_valid, m_axis_ready);
            end
         end
         if (s_axis_ready === 1'b1) break;
         stalls++;
         waits++;
         if (waits > 500) begin
            n_cmp++;
            n_err++;
            $display("FAIL handshake_timeout: s_axis_ready low for %0d cycles, required 1", waits);
            break;
         end
      end
      acc_c.push_back(cyc);
      @(posedge sysclk);
      #1;
   endtask

   task automatic send_frame();
      bit tcp, udp;
      int cls;
      cls = classify(fd[0], fk[0], fd.size() == 1, tcp, udp);
      case (cls)
         0: begin
            e_pass++;
            if (tcp) e_tcp++;
            if (udp) e_udp++;
            foreach (fd[i]) begin
               exp_d.push_back(fd[i]);
               exp_k.push_back(fk[i]);
               exp_l.push_back(i == fd.size() - 1);
            end
         end
         1:       e_drop++;
         default: e_runt++;
      endcase
      for (int b = 0; b < fd.size(); b++) begin
         drive_beat(fd[b], fk[b], b == fd.size() - 1);
         if (b == 0 && mid_flip) begin
            promisc_en = 1'($urandom_range(0, 1));
            mcast_en   = 1'($urandom_range(0, 1));
            local_mac  = {16'($urandom), 32'($urandom)};
         end
      end
      s_axis_valid = 1'b0;
      s_axis_last  = 1'b0;
   endtask

   task automatic drain();
      int w = 0;
      rand_rdy = 1'b0;
      @(posedge sysclk);
      #1;
      m_axis_ready = 1'b1;
      while ((m_axis_valid === 1'b1 || got_d.size() < exp_d.size()) && w < 100) begin
         @(posedge sysclk);
         #1;
         w++;
      end
      if (w >= 100) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: got %0d beats, required %0d", got_d.size(), exp_d.size());
      end
   endtask

   task automatic clear_q();
      got_d.delete(); got_k.delete(); got_l.delete(); got_c.delete();
      exp_d.delete(); exp_k.delete(); exp_l.delete(); acc_c.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      m_axis_ready = 1'b0;
      repeat (3) @(posedge sysclk);
      #1;
      @(negedge sysclk);
      n_cmp++;
      if (m_axis_valid !== 1'b0 || m_axis_data !== '0 || m_axis_keep !== '0 || m_axis_last !== 1'b0) begin
         n_err++;
         $display("FAIL reset_out: valid=%b keep=%h last=%b, required all zero", m_axis_valid, m_axis_keep, m_axis_last);
      end
      n_cmp++;
      if ({pass_cnt, drop_cnt, runt_cnt, tcp_cnt, udp_cnt} !== 160'd0) begin
         n_err++;
         $display("FAIL reset_cnt: counters=%h, required 0", {pass_cnt, drop_cnt, runt_cnt, tcp_cnt, udp_cnt});
      end
      @(posedge sysclk);
      #1;
      rst = 1'b0;
      @(negedge sysclk);
      n_cmp++;
      if (s_axis_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_ready: s_axis_ready=%b, required 1", s_axis_ready);
      end
      @(posedge sysclk);
      #1;
      clear_q();
   endtask

   task automatic test_unicast_tcp();
      local_mac = 48'h02_11_22_33_44_55;
      promisc_en = 1'b0;
      mcast_en = 1'b0;
      m_axis_ready = 1'b1;
      build_frame(local_mac, 16'h0800, 8'h45, 8'd6, 3, 32);
      send_frame();
      drain();
      n_cmp++;
      if (got_d.size() != 3) begin
         n_err++;
         $display("FAIL uni_beats: got %0d beats, required 3", got_d.size());
      end
      for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
         n_cmp++;
         if (got_d[i] !== exp_d[i] || got_k[i] !== exp_k[i] || got_l[i] !== exp_l[i]) begin
            n_err++;
            $display("FAIL uni_beat%0d: got keep=%h last=%b data=%h, required keep=%h last=%b data=%h",
                     i, got_k[i], got_l[i], got_d[i], exp_k[i], exp_l[i], exp_d[i]);
         end
         n_cmp++;
         if (got_c[i] - acc_c[i] != 1) begin
            n_err++;
            $display("FAIL uni_latency%0d: got %0d cycles, required 1", i, got_c[i] - acc_c[i]);
         end
      end
      n_cmp++;
      if (pass_cnt !== 32'd1 || tcp_cnt !== 32'd1 || udp_cnt !== 32'd0) begin
         n_err++;
         $display("FAIL uni_cnt: pass=%0d tcp=%0d udp=%0d, required 1 1 0", pass_cnt, tcp_cnt, udp_cnt);
      end
      clear_q();
   endtask

   task automatic test_drop_then_hit();
      build_frame(48'h02_11_22_33_44_66, 16'h0800, 8'h45, 8'd1, 2, 32);
      m_axis_ready = 1'b0;
      stalls = 0;
      send_frame();
      drain();
      n_cmp++;
      if (got_d.size() != 0 || stalls != 0) begin
         n_err++;
         $display("FAIL drop_frame: got %0d beats and %0d stalls, required 0 and 0", got_d.size(), stalls);
      end
      n_cmp++;
      if (drop_cnt !== 32'd1) begin
         n_err++;
         $display("FAIL drop_cnt: got %0d, required 1", drop_cnt);
      end
      clear_q();
      build_frame(local_mac, 16'h86DD, 8'h60, 8'd6, 2, 20);
      send_frame();
      drain();
      n_cmp++;
      if (got_d.size() != 2) begin
         n_err++;
         $display("FAIL hit_beats: got %0d beats, required 2", got_d.size());
      end
      for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
         n_cmp++;
         if (got_d[i] !== exp_d[i] || got_k[i] !== exp_k[i] || got_l[i] !== exp_l[i]) begin
            n_err++;
            $display("FAIL hit_beat%0d: got keep=%h last=%b, required keep=%h last=%b",
                     i, got_k[i], got_l[i], exp_k[i], exp_l[i]);
         end
      end
      n_cmp++;
      if ({pass_cnt, drop_cnt, runt_cnt, tcp_cnt, udp_cnt} !== {e_pass, e_drop, e_runt, e_tcp, e_udp}) begin
         n_err++;
         $display("FAIL hit_cnt: got %h, required %h", {pass_cnt, drop_cnt, runt_cnt, tcp_cnt, udp_cnt},
                  {e_pass, e_drop, e_runt, e_tcp, e_udp});
      end
      clear_q();
   endtask

   task automatic test_bcast_mcast();
      build_frame(48'hFFFF_FFFF_FFFF, 16'h0800, 8'h45, 8'd17, 2, 32);
      send_frame();
      drain();
      n_cmp++;
      if (got_d.size() != 2 || udp_cnt !== 32'd1) begin
         n_err++;
         $display("FAIL bcast: got %0d beats udp=%0d, required 2 beats udp=1", got_d.size(), udp_cnt);
      end
      clear_q();
      mcast_en = 1'b0;
      build_frame(48'h01_00_5E_00_00_01, 16'h0800, 8'h45, 8'd17, 1, 32);
      send_frame();
      drain();
      n_cmp++;
      if (got_d.size() != 0 || drop_cnt !== e_drop) begin
         n_err++;
         $display("FAIL mcast_off: got %0d beats drop=%0d, required 0 beats drop=%0d", got_d.size(), drop_cnt, e_drop);
      end
      clear_q();
      mcast_en = 1'b1;
      build_frame(48'h01_00_5E_00_00_01, 16'h0800, 8'h45, 8'd99, 1, 32);
      send_frame();
      drain();
      n_cmp++;
      if (got_d.size() != 1 || (got_d.size() == 1 && got_d[0] !== fd[0])) begin
         n_err++;
         $display("FAIL mcast_on: got %0d beats, required 1 matching beat", got_d.size());
      end
      n_cmp++;
      if ({pass_cnt, drop_cnt, runt_cnt, tcp_cnt, udp_cnt} !== {e_pass, e_drop, e_runt, e_tcp, e_udp}) begin
         n_err++;
         $display("FAIL mcast_cnt: got %h, required %h", {pass_cnt, drop_cnt, runt_cnt, tcp_cnt, udp_cnt},
                  {e_pass, e_drop, e_runt, e_tcp, e_udp});
      end
      mcast_en = 1'b0;
      clear_q();
   endtask

   task automatic test_runt();
      logic [31:0] pass_before;
      int lens [4] = '{12, 13, 14, 23};
      promisc_en = 1'b1;
      pass_before = pass_cnt;
      foreach (lens[j]) begin
         build_frame({16'($urandom), 32'($urandom)}, 16'h0800, 8'h45, 8'd6, 1, lens[j]);
         send_frame();
         drain();
         n_cmp++;
         if (got_d.size() != exp_d.size()) begin
            n_err++;
            $display("FAIL runt_len%0d: got %0d beats, required %0d", lens[j], got_d.size(), exp_d.size());
         end
         clear_q();
      end
      n_cmp++;
      if (runt_cnt !== 32'd2 || pass_cnt !== pass_before + 32'd2 || tcp_cnt !== e_tcp) begin
         n_err++;
         $display("FAIL runt_cnt: runt=%0d pass=%0d tcp=%0d, required runt=2 pass=%0d tcp=%0d",
                  runt_cnt, pass_cnt, tcp_cnt, pass_before + 32'd2, e_tcp);
      end
      promisc_en = 1'b0;
   endtask

   task automatic test_backpressure();
      build_frame(local_mac, 16'h0800, 8'h45, 8'd6, 5, 27);
      rand_rdy = 1'b1;
      chk_bp = 1'b1;
      send_frame();
      chk_bp = 1'b0;
      drain();
      n_cmp++;
      if (got_d.size() != 5) begin
         n_err++;
         $display("FAIL bp_beats: got %0d beats, required 5", got_d.size());
      end
      for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
         n_cmp++;
         if (got_d[i] !== exp_d[i] || got_k[i] !== exp_k[i] || got_l[i] !== exp_l[i]) begin
            n_err++;
            $display("FAIL bp_beat%0d: got keep=%h last=%b, required keep=%h last=%b",
                     i, got_k[i], got_l[i], exp_k[i], exp_l[i]);
         end
      end
      clear_q();
   endtask

   task automatic test_cnt_clr();
      build_frame(local_mac, 16'h0800, 8'h45, 8'd17, 1, 32);
      m_axis_ready = 1'b1;
      s_axis_data  = fd[0];
      s_axis_keep  = fk[0];
      s_axis_last  = 1'b1;
      s_axis_valid = 1'b1;
      cnt_clr      = 1'b1;
      @(negedge sysclk);
      n_cmp++;
      if (s_axis_ready !== 1'b1) begin
         n_err++;
         $display("FAIL clr_ready: s_axis_ready=%b, required 1", s_axis_ready);
      end
      @(posedge sysclk);
      #1;
      s_axis_valid = 1'b0;
      s_axis_last  = 1'b0;
      cnt_clr      = 1'b0;
      @(negedge sysclk);
      n_cmp++;
      if ({pass_cnt, drop_cnt, runt_cnt, tcp_cnt, udp_cnt} !== 160'd0) begin
         n_err++;
         $display("FAIL clr_cnt: counters=%h, required 0", {pass_cnt, drop_cnt, runt_cnt, tcp_cnt, udp_cnt});
      end
      n_cmp++;
      if (m_axis_valid !== 1'b1 || m_axis_data !== fd[0]) begin
         n_err++;
         $display("FAIL clr_fwd: m_axis_valid=%b, required 1 with the cleared-cycle beat", m_axis_valid);
      end
      {e_pass, e_drop, e_runt, e_tcp, e_udp} = '0;
      @(posedge sysclk);
      #1;
      drain();
      clear_q();
   endtask

   task automatic test_rst_mid();
      logic [DW-1:0] d;
      promisc_en = 1'b0;
      mcast_en = 1'b0;
      m_axis_ready = 1'b1;
      build_frame(local_mac, 16'h0800, 8'h45, 8'd6, 3, 32);
      d = fd[2];
      drive_beat(fd[0], fk[0], 1'b0);
      drive_beat(fd[1], fk[1], 1'b0);
      rst = 1'b1;
      s_axis_valid = 1'b0;
      m_axis_ready = 1'b0;
      @(posedge sysclk);
      #1;
      @(negedge sysclk);
      n_cmp++;
      if (m_axis_valid !== 1'b0 || pass_cnt !== 32'd0) begin
         n_err++;
         $display("FAIL rst_mid: m_axis_valid=%b pass=%0d, required 0 and 0", m_axis_valid, pass_cnt);
      end
      @(posedge sysclk);
      #1;
      rst = 1'b0;
      {e_pass, e_drop, e_runt, e_tcp, e_udp} = '0;
      clear_q();
      m_axis_ready = 1'b1;
      for (int i = 0; i < 6; i++) d[8*i +: 8] = (i == 0) ? 8'h02 : 8'hAA;
      fd.delete();
      fk.delete();
      fd.push_back(d);
      fk.push_back('1);
      send_frame();
      drain();
      n_cmp++;
      if (got_d.size() != 0 || drop_cnt !== 32'd1 || pass_cnt !== 32'd0) begin
         n_err++;
         $display("FAIL rst_idle: got %0d beats drop=%0d pass=%0d, required 0 1 0", got_d.size(), drop_cnt, pass_cnt);
      end
      clear_q();
   endtask

   task automatic test_random();
      logic [47:0] dm;
      logic [15:0] et;
      logic [7:0]  vihl, proto;
      mid_flip = 1'b1;
      rand_rdy = 1'b1;
      repeat (40) begin
         promisc_en = ($urandom_range(0, 4) == 0);
         mcast_en   = 1'($urandom_range(0, 1));
         local_mac  = {16'($urandom), 32'($urandom)};
         local_mac[40] = 1'b0;
         case ($urandom_range(0, 3))
            0:       dm = local_mac;
            1:       dm = 48'hFFFF_FFFF_FFFF;
            2:       begin dm = {16'($urandom), 32'($urandom)}; dm[40] = 1'b1; end
            default: begin dm = {16'($urandom), 32'($urandom)}; dm[40] = 1'b0; end
         endcase
         et   = $urandom_range(0, 1) ? 16'h0800 : 16'($urandom);
         vihl = $urandom_range(0, 1) ? 8'h45 : 8'($urandom);
         case ($urandom_range(0, 2))
            0:       proto = 8'd6;
            1:       proto = 8'd17;
            default: proto = 8'($urandom);
         endcase
         build_frame(dm, et, vihl, proto, $urandom_range(1, 4), $urandom_range(1, KW));
         send_frame();
      end
      mid_flip = 1'b0;
      drain();
      n_cmp++;
      if (got_d.size() != exp_d.size()) begin
         n_err++;
         $display("FAIL rand_beats: got %0d beats, required %0d", got_d.size(), exp_d.size());
      end
      for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
         n_cmp++;
         if (got_d[i] !== exp_d[i] || got_k[i] !== exp_k[i] || got_l[i] !== exp_l[i]) begin
            n_err++;
            $display("FAIL rand_beat%0d: got keep=%h last=%b, required keep=%h last=%b",
                     i, got_k[i], got_l[i], exp_k[i], exp_l[i]);
         end
      end
      n_cmp++;
      if ({pass_cnt, drop_cnt, runt_cnt, tcp_cnt, udp_cnt} !== {e_pass, e_drop, e_runt, e_tcp, e_udp}) begin
         n_err++;
         $display("FAIL rand_cnt: got %h, required %h", {pass_cnt, drop_cnt, runt_cnt, tcp_cnt, udp_cnt},
                  {e_pass, e_drop, e_runt, e_tcp, e_udp});
      end
      clear_q();
   endtask

   initial begin
      test_reset();
      test_unicast_tcp();
      test_drop_then_hit();
      test_bcast_mcast();
      test_runt();
      test_backpressure();
      test_cnt_clr();
      test_random();
      test_rst_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
